// File: rtl/systolic_out_deskew.sv
// systolic_out_deskew: re-aligns skewed per-column array results into full rows, streamed out valid/ready.
// Optional DESKEW_RELU_EN: clamps negative elements to 0 at capture and adds the relu_hits pulse output.
`default_nettype none

module systolic_out_deskew #(
  parameter int N     = 3,
  parameter int ACC_W = 24,
  parameter int DEPTH = 4,
  parameter int ROWS  = 3,
  localparam int IW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               clr,
  input  logic [N-1:0]       col_valid,
  input  logic [N*ACC_W-1:0] col_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*ACC_W-1:0] out_row,
  output logic [IW-1:0]      out_idx,
  output logic               out_last,
  output logic               ovf,
  output logic               busy
`ifdef DESKEW_RELU_EN
  , output logic             relu_hits
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ACC_W-1:0] mem_q [DEPTH][N];
  logic [N-1:0]     fl_q  [DEPTH];
  logic [N-1:0]     fl_d  [DEPTH];
  logic [AW-1:0]    wp_q  [N];
  logic [AW-1:0]    wp_d  [N];
  logic [AW-1:0]    rp_q;
  logic [IW-1:0]    row_cnt_q;
  logic             ovf_q;
  logic             ovf_d;
  logic [N-1:0]     acc;
  logic [ACC_W-1:0] wdat [N];
  logic             pop;
  logic             any_fl;
`ifdef DESKEW_RELU_EN
  logic [N-1:0]     neg;
  logic             relu_hits_q;
`endif

  // A row is complete only when every column's flag in the read slot is set.
  assign out_valid = &fl_q[rp_q];
  assign pop       = out_valid & out_ready;
  assign out_idx   = row_cnt_q;
  assign out_last  = (row_cnt_q == IW'(ROWS - 1));
  assign ovf       = ovf_q;
  assign busy      = any_fl;
`ifdef DESKEW_RELU_EN
  assign relu_hits = relu_hits_q;
`endif

  always_comb begin
    for (int j = 0; j < N; j++) begin
      wdat[j] = col_data[j*ACC_W +: ACC_W];
`ifdef DESKEW_RELU_EN
      neg[j] = wdat[j][ACC_W-1];
      if (neg[j]) wdat[j] = '0;
`endif
    end
  end

  always_comb begin
    out_row = '0;
    for (int j = 0; j < N; j++) out_row[j*ACC_W +: ACC_W] = mem_q[rp_q][j];
  end

  always_comb begin
    any_fl = 1'b0;
    for (int s = 0; s < DEPTH; s++) any_fl = any_fl | (|fl_q[s]);
  end

  // Pop clears the read slot before column writes, so a write into a slot
  // being popped in the same cycle lands cleanly without overflow.
  always_comb begin
    fl_d  = fl_q;
    wp_d  = wp_q;
    ovf_d = ovf_q;
    acc   = '0;
    if (pop) fl_d[rp_q] = '0;
    for (int j = 0; j < N; j++) begin
      if (col_valid[j]) begin
        if (!fl_q[wp_q[j]][j] || (pop && (wp_q[j] == rp_q))) begin
          fl_d[wp_q[j]][j] = 1'b1;
          wp_d[j]          = wp_q[j] + AW'(1);
          acc[j]           = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int s = 0; s < DEPTH; s++) begin
        fl_q[s] <= '0;
        for (int j = 0; j < N; j++) mem_q[s][j] <= '0;
      end
      for (int j = 0; j < N; j++) wp_q[j] <= '0;
      rp_q      <= '0;
      row_cnt_q <= '0;
      ovf_q     <= 1'b0;
`ifdef DESKEW_RELU_EN
      relu_hits_q <= 1'b0;
`endif
    end else if (clr) begin
      for (int s = 0; s < DEPTH; s++) fl_q[s] <= '0;
      for (int j = 0; j < N; j++) wp_q[j] <= '0;
      rp_q      <= '0;
      row_cnt_q <= '0;
      ovf_q     <= 1'b0;
`ifdef DESKEW_RELU_EN
      relu_hits_q <= 1'b0;
`endif
    end else begin
      fl_q  <= fl_d;
      wp_q  <= wp_d;
      ovf_q <= ovf_d;
      for (int j = 0; j < N; j++) begin
        if (acc[j]) mem_q[wp_q[j]][j] <= wdat[j];
      end
      if (pop) begin
        rp_q      <= rp_q + AW'(1);
        row_cnt_q <= (row_cnt_q == IW'(ROWS - 1)) ? '0 : row_cnt_q + IW'(1);
      end
`ifdef DESKEW_RELU_EN
      relu_hits_q <= |(acc & neg);
`endif
    end
  end

endmodule

`default_nettype wire
